// File: rtl/digital_calculator_if.sv
// Operand/opcode/result bundle for digital_calculator.
//   a, b        : 8-bit unsigned operands (master -> slave)
//   op          : 3-bit operation select   (master -> slave)
//   result      : 16-bit registered result (slave -> master)
//   add_result, sub_result, mul_result, div_result :
//                 one-hot indicators of the latched operation (slave -> master)
interface digital_calculator_if;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] result;
    logic        add_result;
    logic        sub_result;
    logic        mul_result;
    logic        div_result;

    modport master (
        output a, b, op,
        input  result, add_result, sub_result, mul_result, div_result
    );

    modport slave (
        input  a, b, op,
        output result, add_result, sub_result, mul_result, div_result
    );
endinterface

// File: rtl/digital_calculator.sv
// 8-bit unsigned four-function calculator with a single registered 16-bit
// result and one-hot operation flags. Inputs are sampled every rising edge and
// the outputs reflect them one cycle later; no other state is kept.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears result and flags
//   bus : slave side of digital_calculator_if (a, b, op in; result and flags out)
// Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx reserved (result 0, no flag).
module digital_calculator (
    input logic                  clk,
    input logic                  rst,
    digital_calculator_if.slave  bus
);
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_sel_t;

    op_sel_t     sel;
    logic [15:0] next_result;
    logic [3:0]  next_flags;   // {add, sub, mul, div}
    logic [8:0]  rem;
    logic [7:0]  quo;

    // 8-stage unrolled restoring divider; rem carries one extra bit so the
    // shifted partial remainder can be compared against b without overflow.
    always_comb begin
        rem = '0;
        quo = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            rem = {rem[7:0], bus.a[7 - i]};
            if (rem >= {1'b0, bus.b}) begin
                rem        = rem - {1'b0, bus.b};
                quo[7 - i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel         = op_sel_t'(bus.op[1:0]);
        next_result = '0;
        next_flags  = '0;
        if (!bus.op[2]) begin
            unique case (sel)
                OP_ADD: begin
                    next_result = {7'b0, {1'b0, bus.a} + {1'b0, bus.b}};
                    next_flags  = 4'b1000;
                end
                OP_SUB: begin
                    next_result = {8'b0, bus.a} - {8'b0, bus.b};
                    next_flags  = 4'b0100;
                end
                OP_MUL: begin
                    next_result = {8'b0, bus.a} * {8'b0, bus.b};
                    next_flags  = 4'b0010;
                end
                OP_DIV: begin
                    next_result = (bus.b == 8'd0) ? '1 : {rem[7:0], quo};
                    next_flags  = 4'b0001;
                end
                default: begin
                    next_result = '0;
                    next_flags  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.result     <= '0;
            bus.add_result <= 1'b0;
            bus.sub_result <= 1'b0;
            bus.mul_result <= 1'b0;
            bus.div_result <= 1'b0;
        end else begin
            bus.result     <= next_result;
            bus.add_result <= next_flags[3];
            bus.sub_result <= next_flags[2];
            bus.mul_result <= next_flags[1];
            bus.div_result <= next_flags[0];
        end
    end
endmodule

// File: tb/tb_digital_calculator.sv
// Directed self-checking bench for digital_calculator.
module tb_digital_calculator;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    digital_calculator_if bus ();

    digital_calculator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {bus.add_result, bus.sub_result, bus.mul_result, bus.div_result};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge, capture at the next rising edge, sample 1 time unit later.
    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [15:0] exp_res, input logic [3:0] exp_fl);
        @(negedge clk);
        bus.a  = a;
        bus.b  = b;
        bus.op = op;
        @(posedge clk);
        #1;
        check({tag, "_res"}, bus.result, exp_res);
        check({tag, "_flg"}, {12'b0, flags()}, {12'b0, exp_fl});
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        bus.a  = 8'd9;
        bus.b  = 8'd3;
        bus.op = 3'b010;

        // Reset held across edges: outputs stay cleared.
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", bus.result, 16'h0000);
        check("rst_flg", {12'b0, flags()}, 16'h0000);

        // Release; first edge captures 9*3.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_res", bus.result, 16'd27);
        check("first_flg", {12'b0, flags()}, 16'h0002);

        run("add_carry", 8'd255, 8'd255, 3'b000, 16'd510,   4'b1000);
        run("sub_wrap",  8'd5,   8'd10,  3'b001, 16'hFFFB,  4'b0100);
        run("sub_pos",   8'd200, 8'd55,  3'b001, 16'd145,   4'b0100);
        run("mul_max",   8'd255, 8'd255, 3'b010, 16'hFE01,  4'b0010);
        run("div_norm",  8'd200, 8'd7,   3'b011, 16'h041C,  4'b0001);
        run("div_zero",  8'd123, 8'd0,   3'b011, 16'hFFFF,  4'b0001);
        run("div_small", 8'd3,   8'd200, 3'b011, 16'h0300,  4'b0001);
        run("div_one",   8'd255, 8'd1,   3'b011, 16'h00FF,  4'b0001);

        // Back-to-back: op changes every cycle, each result exactly one edge later.
        run("b2b_add",   8'd12,  8'd34,  3'b000, 16'd46,    4'b1000);
        @(negedge clk);
        bus.a  = 8'd100;
        bus.b  = 8'd9;
        bus.op = 3'b011;
        #1;
        check("b2b_hold", bus.result, 16'd46);
        @(posedge clk);
        #1;
        check("b2b_div_res", bus.result, 16'h010B);
        check("b2b_div_flg", {12'b0, flags()}, 16'h0001);
        run("b2b_rsv",   8'd100, 8'd9,   3'b101, 16'h0000,  4'b0000);
        run("rsv_111",   8'd77,  8'd3,   3'b111, 16'h0000,  4'b0000);
        run("mul_mid",   8'd16,  8'd16,  3'b010, 16'h0100,  4'b0010);

        // Asynchronous reset between clock edges clears outputs at once.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_res", bus.result, 16'h0000);
        check("arst_flg", {12'b0, flags()}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        run("post_rst",  8'd9,   8'd3,   3'b001, 16'd6,     4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
